// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix display controller.
//   state_e  - stepping FSM states (WAIT / REQ / DEAD)
//   GS_DEF   - default grid side length
//   row_of() - extracts row r of a GS_DEF x GS_DEF frame (bit c = column c)
package matrix_pkg;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_REQ  = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   localparam int GS_DEF    = 8;
   localparam int GS_DEF_RW = $clog2(GS_DEF);

   function automatic logic [GS_DEF-1:0] row_of(input logic [GS_DEF*GS_DEF-1:0] frame,
                                                input logic [GS_DEF_RW-1:0]     r);
      row_of = frame[r*GS_DEF +: GS_DEF];
   endfunction

endpackage

// File: rtl/row_scanner.sv
// row_scanner: free-running row-multiplexed scan of a GS x GS frame.
//   clk_i, reset_i - clock, asynchronous active-low reset
//   i_pend_frame   - newest completed frame; copied into the shown frame at the row wrap
//   i_blank        - forces column data to zero (blink off-phase)
//   o_row          - one-hot row select (registered)
//   o_col          - column data of the selected row (registered)
module row_scanner
   import matrix_pkg::*;
#(
   parameter int GS         = GS_DEF,
   parameter int ROW_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [GS*GS-1:0] i_pend_frame,
   input  logic             i_blank,
   output logic [GS-1:0]    o_row,
   output logic [GS-1:0]    o_col
);

   localparam int            RW       = (GS > 1) ? $clog2(GS) : 1;
   localparam logic [7:0]    DIV_LAST = 8'(ROW_CYCLES - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(GS - 1);

   logic [7:0]       r_div;
   logic [RW-1:0]    r_row;
   logic [GS*GS-1:0] r_frame;

   logic             w_step;
   logic             w_wrap;
   logic [RW-1:0]    w_row_nxt;
   logic [GS*GS-1:0] w_frame_nxt;
   logic [GS-1:0]    w_col_raw;

   // Next row index; the shown frame is only replaced at the wrap so a row never mixes frames.
   always_comb begin
      w_step      = (r_div == DIV_LAST);
      w_wrap      = w_step && (r_row == ROW_LAST);
      w_row_nxt   = r_row;
      w_frame_nxt = r_frame;
      if (w_wrap) begin
         w_row_nxt   = '0;
         w_frame_nxt = i_pend_frame;
      end else if (w_step) begin
         w_row_nxt   = r_row + RW'(1);
      end else begin
         w_row_nxt   = r_row;
      end
   end

   generate
      if (GS == GS_DEF) begin : g_pkg_slice
         // Column data of the upcoming row through the shared slicing helper.
         always_comb w_col_raw = row_of(w_frame_nxt, w_row_nxt);
      end else begin : g_generic_slice
         // Column data of the upcoming row for non-default grid sizes.
         always_comb w_col_raw = w_frame_nxt[w_row_nxt*GS +: GS];
      end
   endgenerate

   // Divider, row counter, shown frame and registered row/column outputs.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_div   <= 8'd0;
         r_row   <= '0;
         r_frame <= '0;
         o_row   <= GS'(1);
         o_col   <= '0;
      end else begin
         r_div   <= w_step ? 8'd0 : r_div + 8'd1;
         r_row   <= w_row_nxt;
         r_frame <= w_frame_nxt;
         o_row   <= GS'(1) << w_row_nxt;
         o_col   <= i_blank ? '0 : w_col_raw;
      end
   end

endmodule

// File: rtl/matrix_ctrl.sv
// matrix_ctrl: paces the game through the e_act/d_act handshake, captures frames and
// drives a row-multiplexed GS x GS LED matrix; blinks the last frame after game over.
//   clk_i, reset_i - clock, asynchronous active-low reset
//   matrix_i       - frame from the action block, row r = matrix_i[r*GS +: GS]
//   d_act_i        - step done;  dead_i - game over (sampled only on the step-done edge)
//   e_act_o        - step request (registered)
//   row_o, col_o   - one-hot row select and its column data
//   step_cnt_o     - completed steps, saturating;  error_o - sticky handshake timeout
module matrix_ctrl
   import matrix_pkg::*;
#(
   parameter int GS          = GS_DEF,
   parameter int STEP_CYCLES = 50,
   parameter int ROW_CYCLES  = 4,
   parameter int TIMEOUT     = 64,
   parameter int BLINK_STEPS = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [GS*GS-1:0] matrix_i,
   input  logic             d_act_i,
   input  logic             dead_i,
   output logic             e_act_o,
   output logic [GS-1:0]    row_o,
   output logic [GS-1:0]    col_o,
   output logic [15:0]      step_cnt_o,
   output logic             error_o
);

   localparam logic [15:0] STEP_LAST  = 16'(STEP_CYCLES);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_STEPS * STEP_CYCLES - 1);

   state_e           r_state;
   logic [15:0]      r_wait_cnt;
   logic [15:0]      r_to_cnt;
   logic [31:0]      r_blink_cnt;
   logic             r_blank;
   logic [GS*GS-1:0] r_pend;

   // Stepping FSM: wait period, request/timeout, and the blinking game-over state.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state     <= ST_WAIT;
         r_wait_cnt  <= 16'd0;
         r_to_cnt    <= 16'd0;
         r_blink_cnt <= 32'd0;
         r_blank     <= 1'b0;
         r_pend      <= '0;
         e_act_o     <= 1'b0;
         step_cnt_o  <= 16'd0;
         error_o     <= 1'b0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               // The request is held back while d_act_i is still high.
               if ((r_wait_cnt == STEP_LAST) && !d_act_i) begin
                  r_state  <= ST_REQ;
                  e_act_o  <= 1'b1;
                  r_to_cnt <= 16'd0;
               end else if (r_wait_cnt != STEP_LAST) begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end else begin
                  r_wait_cnt <= r_wait_cnt;
               end
            end
            ST_REQ: begin
               if (d_act_i) begin
                  r_pend     <= matrix_i;
                  e_act_o    <= 1'b0;
                  r_wait_cnt <= 16'd0;
                  if (step_cnt_o != 16'hFFFF) begin
                     step_cnt_o <= step_cnt_o + 16'd1;
                  end
                  if (dead_i) begin
                     r_state     <= ST_DEAD;
                     r_blink_cnt <= 32'd0;
                     r_blank     <= 1'b0;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end else if (r_to_cnt == TO_LAST) begin
                  error_o    <= 1'b1;
                  e_act_o    <= 1'b0;
                  r_wait_cnt <= 16'd0;
                  r_state    <= ST_WAIT;
               end else begin
                  r_to_cnt <= r_to_cnt + 16'd1;
               end
            end
            ST_DEAD: begin
               e_act_o <= 1'b0;
               if (r_blink_cnt == BLINK_LAST) begin
                  r_blink_cnt <= 32'd0;
                  r_blank     <= ~r_blank;
               end else begin
                  r_blink_cnt <= r_blink_cnt + 32'd1;
               end
            end
            default: begin
               r_state <= ST_WAIT;
               e_act_o <= 1'b0;
            end
         endcase
      end
   end

   row_scanner #(
      .GS         (GS),
      .ROW_CYCLES (ROW_CYCLES)
   ) u_scan (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .i_pend_frame (r_pend),
      .i_blank      (r_blank),
      .o_row        (row_o),
      .o_col        (col_o)
   );

endmodule

// File: tb/tb_matrix_ctrl.sv
module tb_matrix_ctrl;

   localparam logic [63:0] F1 = 64'h40041000_01802002;
   localparam logic [63:0] FA = 64'hFFFFFFFF_FFFFFFFF;
   localparam logic [63:0] FB = 64'h01234567_89ABCDEF;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [63:0] matrix;
   logic        d_act, dead;
   logic        e_act;
   logic [7:0]  row, col;
   logic [15:0] step;
   logic        err;

   logic [63:0] matrix2;
   logic        d_act2, dead2;
   logic        e_act2;
   logic [7:0]  row2, col2;
   logic [15:0] step2;
   logic        err2;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   matrix_ctrl u_dut (
      .clk_i(clk), .reset_i(reset_i), .matrix_i(matrix), .d_act_i(d_act), .dead_i(dead),
      .e_act_o(e_act), .row_o(row), .col_o(col), .step_cnt_o(step), .error_o(err)
   );

   matrix_ctrl #(.GS(8), .STEP_CYCLES(2), .ROW_CYCLES(8)) u_fast (
      .clk_i(clk), .reset_i(reset_i), .matrix_i(matrix2), .d_act_i(d_act2), .dead_i(dead2),
      .e_act_o(e_act2), .row_o(row2), .col_o(col2), .step_cnt_o(step2), .error_o(err2)
   );

   function automatic logic [7:0] f_row(input logic [63:0] f, input int r);
      logic [63:0] t;
      t = f >> (r * 8);
      return t[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
   endtask

   // Ticks until e_act rises; n = number of edges taken (200 means it never rose).
   task automatic wait_req(output int n);
      n = 0;
      while (!e_act && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int lat;
      int wrap;
      int dstart;

      reset_i = 1'b0;
      matrix  = 64'd0; d_act  = 1'b0; dead  = 1'b0;
      matrix2 = 64'd0; d_act2 = 1'b0; dead2 = 1'b0;
      tick(); tick();
      chk1 ("rst_e_act", e_act, 1'b0);
      chk8 ("rst_row",   row,   8'h01);
      chk8 ("rst_col",   col,   8'h00);
      chk16("rst_step",  step,  16'd0);
      chk1 ("rst_err",   err,   1'b0);
      reset_i = 1'b1;
      cyc = 0;

      // First step: request 51 edges after release, answer 3 cycles after the rise.
      wait_req(n);
      chki("s1_rise_delay", n, 51);
      matrix = F1;
      tick();
      chk1("s1_e_act_hold1", e_act, 1'b1);
      tick();
      chk1("s1_e_act_hold2", e_act, 1'b1);
      d_act = 1'b1;
      tick();
      d_act = 1'b0;
      chk1 ("s1_e_act_fall", e_act, 1'b0);
      chk16("s1_step",       step,  16'd1);
      lat  = cyc;
      wrap = (lat / 32 + 1) * 32;

      // Display update at the next wrap, stray d_act ignored, then an unanswered request times out.
      for (int i = 1; i <= 115; i++) begin
         d_act = (i == 10);
         tick();
         chk8 ("s2_row",   row,  8'h01 << ((cyc / 4) % 8));
         chk8 ("s2_col",   col,  (cyc >= wrap) ? f_row(F1, (cyc / 4) % 8) : 8'h00);
         chk16("s2_step",  step, 16'd1);
         chk1 ("s3_e_act", e_act, (i >= 51) && (i < 115));
         chk1 ("s3_err",   err,   (i >= 115));
      end

      // Steps 2..5; game over reported together with step 5.
      for (int k = 2; k <= 5; k++) begin
         wait_req(n);
         chki("s4_rise_delay", n, 51);
         d_act = 1'b1;
         dead  = (k == 5);
         tick();
         d_act = 1'b0;
         dead  = 1'b0;
         chk16("s4_step",  step,  16'(k));
         chk1 ("s4_e_act", e_act, 1'b0);
      end
      dstart = cyc;

      // Dead: no more requests, count frozen, frame/blank alternating every 200 cycles.
      for (int t = 1; t <= 2000; t++) begin
         tick();
         chk1 ("dead_e_act", e_act, 1'b0);
         chk16("dead_step",  step,  16'd5);
         chk8 ("dead_row",   row,   8'h01 << ((cyc / 4) % 8));
         chk8 ("dead_col",   col,
               ((((cyc - dstart) - 1) / 200) % 2 != 0) ? 8'h00 : f_row(F1, (cyc / 4) % 8));
      end

      // Leave DEAD by reset, build up step/error state, then reset in the middle of REQ.
      reset_i = 1'b0;
      tick(); tick();
      reset_i = 1'b1;
      cyc = 0;
      wait_req(n);
      chki("ra_rise_delay", n, 51);
      d_act = 1'b1;
      tick();
      d_act = 1'b0;
      chk16("ra_step", step, 16'd1);
      wait_req(n);
      chki("ra_rise2_delay", n, 51);
      for (int i = 1; i <= 64; i++) tick();
      chk1("ra_timeout_err",   err,   1'b1);
      chk1("ra_timeout_e_act", e_act, 1'b0);
      wait_req(n);
      chki("ra_rise3_delay", n, 51);
      #2;
      reset_i = 1'b0;
      #1;
      chk1 ("rb_async_e_act", e_act, 1'b0);
      chk8 ("rb_row",  row,  8'h01);
      chk8 ("rb_col",  col,  8'h00);
      chk16("rb_step", step, 16'd0);
      chk1 ("rb_err",  err,  1'b0);
      tick();
      reset_i = 1'b1;
      cyc = 0;

      // Main instance restarts from WAIT; fast instance gets two frames within one scan.
      for (int i = 1; i <= 140; i++) begin
         d_act2  = (cyc == 3) || (cyc == 7);
         matrix2 = (cyc == 3) ? FA : ((cyc == 7) ? FB : 64'd0);
         tick();
         chk1 ("rb_e_act", e_act, (cyc >= 51) && (cyc < 115));
         chk1 ("rb_err2",  err,   (cyc >= 115));
         chk8 ("rb_col0",  col,   8'h00);
         chk8 ("rb_row0",  row,   8'h01 << ((cyc / 4) % 8));
         chk8 ("fast_row", row2,  8'h01 << ((cyc / 8) % 8));
         chk8 ("fast_col", col2,  (cyc >= 64) ? f_row(FB, (cyc / 8) % 8) : 8'h00);
         chk16("fast_step", step2, (cyc >= 8) ? 16'd2 : ((cyc >= 4) ? 16'd1 : 16'd0));
         if (cyc <= 10) chk1("fast_e_act", e_act2, (cyc == 3) || (cyc == 7));
      end
      d_act2 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
